// File: rtl/usart_pkg.sv
// Shared types and helpers for the buffered USART receiver.
// Holds the receiver state encoding, the FIFO entry layout and small constant functions.
package usart_pkg;

    localparam int MAX_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } rx_state_e;

    typedef struct packed {
        logic                     parity_error;
        logic                     frame_error;
        logic [MAX_DATA_BITS-1:0] data;
    } rx_entry_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    function automatic int mid_of(input int oversample);
        return oversample / 2;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/usart_fifo.sv
// Synchronous FIFO with a registered head entry.
// The head register only changes on a pop or when a push lands in an empty FIFO.
module usart_fifo
    import usart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [clog2(DEPTH):0]   o_count
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_pop_ok;
    logic             w_push_ok;
    logic [AW-1:0]    w_rd_nxt;

    assign o_empty   = (r_count == CW'(0));
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_head;
    assign w_pop_ok  = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign w_rd_nxt  = r_rd + 1'b1;

    // Storage array write port.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointers, occupancy count and registered head.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd <= w_rd_nxt;
            end
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
            if (w_pop_ok) begin
                if (r_count > CW'(1)) begin
                    r_head <= r_mem[w_rd_nxt];
                end else if (w_push_ok) begin
                    r_head <= i_data;
                end
            end else if (w_push_ok && o_empty) begin
                r_head <= i_data;
            end
        end
    end

endmodule

// File: rtl/usart_rx_buffered.sv
// Oversampling USART receiver with majority voting, parity, break detection and an output FIFO.
// The FSM, tick divider and voting run here; received words go through usart_fifo.
module usart_rx_buffered
    import usart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 12
) (
    input  logic                 serial_clock,
    input  logic                 reset_n,
    input  logic [DIV_WIDTH-1:0] clocks_per_bit,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overrun,
    input  logic                 clear_overrun,
    output logic                 break_detect,
    output logic                 rts_pin
);

    localparam int TW = clog2(OVERSAMPLE);
    localparam int CW = clog2(FIFO_DEPTH) + 1;
    localparam int EW = $bits(rx_entry_t);
    localparam logic [TW-1:0] T_MIDM1  = TW'(mid_of(OVERSAMPLE) - 1);
    localparam logic [TW-1:0] T_MID    = TW'(mid_of(OVERSAMPLE));
    localparam logic [TW-1:0] T_MIDP1  = TW'(mid_of(OVERSAMPLE) + 1);
    localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    logic [DIV_WIDTH-1:0] r_div_cnt;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_s0;
    logic                 r_s1;
    rx_state_e            r_state;
    logic [TW-1:0]        r_tcnt;
    logic [2:0]           r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_par_err;
    logic                 r_stop2;
    logic [2:0]           r_mode;
    logic                 r_break;
    logic                 r_overrun;
    logic                 r_rts;

    rx_state_e            w_state_n;
    logic [TW-1:0]        w_tcnt_n;
    logic [2:0]           w_bitcnt_n;
    logic [DATA_BITS-1:0] w_shift_n;
    logic                 w_par_bit_n;
    logic                 w_par_err_n;
    logic                 w_stop2_n;
    logic [2:0]           w_mode_n;
    logic                 w_push;
    logic                 w_break;

    logic [DIV_WIDTH-1:0] w_div;
    logic                 w_tick;
    logic                 w_vote;
    logic                 w_is_break;
    rx_entry_t            w_entry;
    rx_entry_t            w_head;
    logic [EW-1:0]        w_head_bits;
    logic                 w_full;
    logic                 w_empty;
    logic [CW-1:0]        w_count;
    logic                 w_pop;
    logic                 w_push_ok;
    logic [CW-1:0]        w_cnt_n;

    assign w_div  = clocks_per_bit >> TW;
    assign w_tick = (w_div == '0) || (r_div_cnt >= (w_div - 1'b1));
    assign w_vote = maj3(r_s0, r_s1, r_sync2);

    // Break: all-zero data, zero parity bit (cleared when absent) and a low final stop vote.
    assign w_is_break = (r_shift == '0) && !r_par_bit && !w_vote;
    assign w_entry    = {r_par_err, ~w_vote, MAX_DATA_BITS'(r_shift)};

    // Oversample tick divider.
    always_ff @(posedge serial_clock) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Two-flop synchroniser and the two early vote samples.
    always_ff @(posedge serial_clock) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_s0    <= 1'b1;
            r_s1    <= 1'b1;
        end else begin
            r_sync1 <= rx_pin;
            r_sync2 <= r_sync1;
            if (w_tick && (r_tcnt == T_MIDM1)) begin
                r_s0 <= r_sync2;
            end
            if (w_tick && (r_tcnt == T_MID)) begin
                r_s1 <= r_sync2;
            end
        end
    end

    // Receiver state and frame datapath registers.
    always_ff @(posedge serial_clock) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_tcnt    <= '0;
            r_bitcnt  <= 3'd0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_par_err <= 1'b0;
            r_stop2   <= 1'b0;
            r_mode    <= 3'd0;
            r_break   <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_tcnt    <= w_tcnt_n;
            r_bitcnt  <= w_bitcnt_n;
            r_shift   <= w_shift_n;
            r_par_bit <= w_par_bit_n;
            r_par_err <= w_par_err_n;
            r_stop2   <= w_stop2_n;
            r_mode    <= w_mode_n;
            r_break   <= w_break;
        end
    end

    // Next-state and strobe logic; r_mode = {parity_en, parity_odd, two_stop} latched at START entry.
    always_comb begin
        w_state_n   = r_state;
        w_tcnt_n    = r_tcnt;
        w_bitcnt_n  = r_bitcnt;
        w_shift_n   = r_shift;
        w_par_bit_n = r_par_bit;
        w_par_err_n = r_par_err;
        w_stop2_n   = r_stop2;
        w_mode_n    = r_mode;
        w_push      = 1'b0;
        w_break     = 1'b0;
        if (w_tick) begin
            w_tcnt_n = r_tcnt + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    w_tcnt_n = '0;
                    if (!r_sync2) begin
                        w_state_n   = ST_START;
                        w_mode_n    = {parity_en, parity_odd, two_stop};
                        w_par_bit_n = 1'b0;
                        w_par_err_n = 1'b0;
                        w_stop2_n   = 1'b0;
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end
                ST_START: begin
                    if ((r_tcnt == T_MIDP1) && w_vote) begin
                        w_state_n = ST_IDLE;
                        w_tcnt_n  = '0;
                    end else if (r_tcnt == T_LAST) begin
                        w_state_n  = ST_DATA;
                        w_tcnt_n   = '0;
                        w_bitcnt_n = 3'd0;
                    end else begin
                        w_state_n = ST_START;
                    end
                end
                ST_DATA: begin
                    if (r_tcnt == T_MIDP1) begin
                        w_shift_n = {w_vote, r_shift[DATA_BITS-1:1]};
                    end else begin
                        w_shift_n = r_shift;
                    end
                    if (r_tcnt == T_LAST) begin
                        w_tcnt_n = '0;
                        if (r_bitcnt == BIT_LAST) begin
                            w_state_n = r_mode[2] ? ST_PARITY : ST_STOP;
                        end else begin
                            w_bitcnt_n = r_bitcnt + 3'd1;
                        end
                    end else begin
                        w_state_n = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    if (r_tcnt == T_MIDP1) begin
                        w_par_bit_n = w_vote;
                        w_par_err_n = (^r_shift) ^ w_vote ^ r_mode[1];
                    end else if (r_tcnt == T_LAST) begin
                        w_state_n = ST_STOP;
                        w_tcnt_n  = '0;
                    end else begin
                        w_state_n = ST_PARITY;
                    end
                end
                ST_STOP: begin
                    if (r_tcnt == T_MIDP1) begin
                        if (r_mode[0] && !r_stop2 && w_vote) begin
                            w_state_n = ST_STOP;
                        end else if (w_is_break) begin
                            w_break   = 1'b1;
                            w_state_n = ST_BREAK_WAIT;
                            w_tcnt_n  = '0;
                        end else begin
                            w_push    = 1'b1;
                            w_state_n = ST_IDLE;
                            w_tcnt_n  = '0;
                        end
                    end else if (r_tcnt == T_LAST) begin
                        w_stop2_n = 1'b1;
                        w_tcnt_n  = '0;
                    end else begin
                        w_state_n = ST_STOP;
                    end
                end
                ST_BREAK_WAIT: begin
                    w_tcnt_n = '0;
                    if (r_sync2) begin
                        w_state_n = ST_IDLE;
                    end else begin
                        w_state_n = ST_BREAK_WAIT;
                    end
                end
                default: begin
                    w_state_n = ST_IDLE;
                    w_tcnt_n  = '0;
                end
            endcase
        end else begin
            w_tcnt_n = r_tcnt;
        end
    end

    usart_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (serial_clock),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_data  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head    = w_head_bits;
    assign w_pop     = !w_empty && ready;
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_cnt_n   = w_count + CW'(w_push_ok) - CW'(w_pop);

    // Sticky overrun (set beats clear) and rts tracking the post-edge occupancy.
    always_ff @(posedge serial_clock) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
            r_rts     <= 1'b1;
        end else begin
            if (w_push && w_full && !w_pop) begin
                r_overrun <= 1'b1;
            end else if (clear_overrun) begin
                r_overrun <= 1'b0;
            end
            r_rts <= (w_cnt_n >= CW'(FIFO_DEPTH - 1));
        end
    end

    assign data_out     = w_head.data[DATA_BITS-1:0];
    assign parity_error = w_head.parity_error;
    assign frame_error  = w_head.frame_error;
    assign valid        = !w_empty;
    assign overrun      = r_overrun;
    assign break_detect = r_break;
    assign rts_pin      = r_rts;

endmodule

// File: tb/tb_usart_rx_buffered.sv
// Scoreboard bench for usart_rx_buffered: directed frames push expected entries,
// an independent monitor pops and compares whenever the DUT hands over a word.
module tb_usart_rx_buffered;
    import usart_pkg::*;

    localparam int BIT = 32;

    logic        serial_clock = 1'b0;
    logic        reset_n;
    logic [11:0] clocks_per_bit;
    logic        parity_en;
    logic        parity_odd;
    logic        two_stop;
    logic        rx_pin;
    logic [7:0]  data_out;
    logic        parity_error;
    logic        frame_error;
    logic        valid;
    logic        ready;
    logic        overrun;
    logic        clear_overrun;
    logic        break_detect;
    logic        rts_pin;

    int          total = 0;
    int          bad = 0;
    int          brk_cnt = 0;
    logic [9:0]  exp_q [$];

    usart_rx_buffered dut (
        .serial_clock   (serial_clock),
        .reset_n        (reset_n),
        .clocks_per_bit (clocks_per_bit),
        .parity_en      (parity_en),
        .parity_odd     (parity_odd),
        .two_stop       (two_stop),
        .rx_pin         (rx_pin),
        .data_out       (data_out),
        .parity_error   (parity_error),
        .frame_error    (frame_error),
        .valid          (valid),
        .ready          (ready),
        .overrun        (overrun),
        .clear_overrun  (clear_overrun),
        .break_detect   (break_detect),
        .rts_pin        (rts_pin)
    );

    always #5 serial_clock = ~serial_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic send_bit(input logic v);
        rx_pin = v;
        repeat (BIT) @(posedge serial_clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                              input logic s1, input logic has_s2, input logic s2);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (has_par) send_bit(pbit);
        send_bit(s1);
        if (has_s2) send_bit(s2);
        rx_pin = 1'b1;
        repeat (2 * BIT) @(posedge serial_clock);
    endtask

    task automatic set_ready(input logic v);
        @(posedge serial_clock);
        #1 ready = v;
    endtask

    // Monitor: every accepted head word is compared against the oldest expectation.
    initial begin : monitor
        logic [9:0] e;
        forever begin
            @(negedge serial_clock);
            if (reset_n && valid && ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: actual=0x%0h required=none", {parity_error, frame_error, data_out});
                end else begin
                    e = exp_q.pop_front();
                    check("pop_entry", 32'({parity_error, frame_error, data_out}), 32'(e));
                end
            end
        end
    end

    always @(negedge serial_clock) begin
        if (break_detect) brk_cnt++;
    end

    initial begin
        reset_n = 1'b0;
        rx_pin = 1'b1;
        ready = 1'b0;
        clear_overrun = 1'b0;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        two_stop = 1'b0;
        clocks_per_bit = 12'd32;
        repeat (4) @(posedge serial_clock);
        @(negedge serial_clock);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_perr", 32'(parity_error), 32'd0);
        check("rst_ferr", 32'(frame_error), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_break", 32'(break_detect), 32'd0);
        check("rst_rts", 32'(rts_pin), 32'd1);
        @(posedge serial_clock);
        #1 reset_n = 1'b1;
        @(posedge serial_clock);
        @(negedge serial_clock);
        check("rts_after_release", 32'(rts_pin), 32'd0);

        // 8N1 0xA5
        set_ready(1'b1);
        exp_q.push_back({1'b0, 1'b0, 8'hA5});
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t1_rts", 32'(rts_pin), 32'd0);
        check("t1_consumed", 32'(exp_q.size()), 32'd0);

        // Parity: even with bit 1 is an error, odd with bit 1 is clean
        parity_en = 1'b1;
        parity_odd = 1'b0;
        exp_q.push_back({1'b1, 1'b0, 8'h3C});
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        parity_odd = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 8'h3C});
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        parity_en = 1'b0;
        parity_odd = 1'b0;

        // Start-bit glitch is rejected, then a clean frame
        rx_pin = 1'b0;
        repeat (8) @(posedge serial_clock);
        rx_pin = 1'b1;
        repeat (3 * BIT) @(posedge serial_clock);
        @(negedge serial_clock);
        check("glitch_idle", 32'(dut.r_state), 32'(ST_IDLE));
        check("glitch_no_push", 32'(valid), 32'd0);
        exp_q.push_back({1'b0, 1'b0, 8'h55});
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Fill the FIFO with ready low; fifth word overruns
        set_ready(1'b0);
        exp_q.push_back({1'b0, 1'b0, 8'h01});
        exp_q.push_back({1'b0, 1'b0, 8'h02});
        exp_q.push_back({1'b0, 1'b0, 8'h03});
        exp_q.push_back({1'b0, 1'b0, 8'h04});
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rts_two_entries", 32'(rts_pin), 32'd0);
        send_frame(8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rts_three_entries", 32'(rts_pin), 32'd1);
        send_frame(8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("overrun_at_full", 32'(overrun), 32'd0);
        send_frame(8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("overrun_set", 32'(overrun), 32'd1);
        check("rts_full", 32'(rts_pin), 32'd1);
        set_ready(1'b1);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge serial_clock);
        check("drain_done", 32'(exp_q.size()), 32'd0);
        @(negedge serial_clock);
        check("drain_valid", 32'(valid), 32'd0);
        check("drain_rts", 32'(rts_pin), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        @(posedge serial_clock);
        #1 clear_overrun = 1'b1;
        @(posedge serial_clock);
        #1 clear_overrun = 1'b0;
        @(negedge serial_clock);
        check("overrun_cleared", 32'(overrun), 32'd0);

        // Break: line low for two frame times
        rx_pin = 1'b0;
        repeat (20 * BIT) @(posedge serial_clock);
        rx_pin = 1'b1;
        repeat (3 * BIT) @(posedge serial_clock);
        check("break_pulses", 32'(brk_cnt), 32'd1);
        check("break_no_push", 32'(valid), 32'd0);
        exp_q.push_back({1'b0, 1'b0, 8'h7E});
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Two stop bits: low second stop is a frame error, both high is clean
        two_stop = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 8'h5A});
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 8'hC3});
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        two_stop = 1'b0;

        // Reset in the middle of a data phase empties everything
        set_ready(1'b0);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge serial_clock);
        check("pre_reset_valid", 32'(valid), 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        repeat (10) @(posedge serial_clock);
        #1 reset_n = 1'b0;
        rx_pin = 1'b1;
        repeat (3) @(posedge serial_clock);
        @(negedge serial_clock);
        check("midreset_valid", 32'(valid), 32'd0);
        check("midreset_rts", 32'(rts_pin), 32'd1);
        @(posedge serial_clock);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge serial_clock);
        @(negedge serial_clock);
        check("post_reset_rts", 32'(rts_pin), 32'd0);
        check("post_reset_valid", 32'(valid), 32'd0);
        set_ready(1'b1);
        exp_q.push_back({1'b0, 1'b0, 8'h9C});
        send_frame(8'h9C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        repeat (BIT) @(posedge serial_clock);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_break_count", 32'(brk_cnt), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usart_rx_buffered.md
# usart_rx_buffered

Parametrised successor to the single-byte USART receiver. Runs in one clock domain, using an internal oversample tick enable instead of a derived sample clock. Supports 5–8 data bits, optional even/odd parity, 1 or 2 stop bits, majority-vote sampling and break detection. Received words, with per-word error flags, go into an internal FIFO that is drained over a valid/ready handshake; `rts_pin` throttles the sender.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5–8.
- `OVERSAMPLE`, 16: ticks per bit; power of two, ≥8.
- `FIFO_DEPTH`, 4: entries; power of two, ≥2.
- `DIV_WIDTH`, 12: width of `clocks_per_bit`.

Ports:
- `serial_clock` in 1: sole clock; all logic on posedge.
- `reset_n` in 1: synchronous, active-low reset.
- `clocks_per_bit` in DIV_WIDTH: serial_clock cycles per bit.
- `parity_en` in 1: 1 = parity bit present.
- `parity_odd` in 1: 1 = odd parity, 0 = even.
- `two_stop` in 1: 1 = two stop bits checked.
- `rx_pin` in 1: asynchronous serial input, idle high.
- `data_out` out DATA_BITS: FIFO head data.
- `parity_error` out 1: head entry had a parity mismatch.
- `frame_error` out 1: head entry had a stop bit sampled low.
- `valid` out 1: FIFO non-empty.
- `ready` in 1: consumer accepts head when `valid && ready`.
- `overrun` out 1: sticky; a word was dropped because the FIFO was full.
- `clear_overrun` in 1: single-cycle pulse that clears `overrun`.
- `break_detect` out 1: one-cycle pulse on break.
- `rts_pin` out 1: 1 = sender must pause.

## Operation
- **Tick divider.** `div = clocks_per_bit >> log2(OVERSAMPLE)`.
  - `div == 0`: tick every cycle.
  - Otherwise: tick when the counter reaches `div-1`; the counter then wraps to 0.
- **Input conditioning.** `rx_pin` passes through a 2-flop synchroniser. Bit value = majority of samples at tick positions `MID-1`, `MID`, `MID+1`, where `MID = OVERSAMPLE/2`.
- **States:** IDLE, START, DATA, PARITY, STOP, BREAK_WAIT. The tick counter `tcnt` (0..OVERSAMPLE-1) resets on each state entry.
- **IDLE:** synchronised low seen on a tick → START.
- **START:**
  - At `tcnt == MID+1`, vote high → IDLE (glitch rejected); vote low → continue.
  - At `tcnt == OVERSAMPLE-1` → DATA.
- **DATA:**
  - Vote shifted in LSB-first at `MID+1`.
  - After DATA_BITS bits → PARITY if `parity_en`, else STOP.
- **PARITY:**
  - `parity_error = XOR(data) ^ parity_bit ^ parity_odd`; nonzero means an error.
  - → STOP at the end of the bit.
- **STOP:**
  - Vote at `MID+1`; low sets `frame_error`.
  - If `two_stop` and this is the first stop bit with a high vote, run one more stop bit.
  - On the final stop vote:
    - Data all zero, parity bit (if present) zero and stop low → `break_detect` pulse, no push, → BREAK_WAIT.
    - Otherwise push {parity_error, frame_error, data} → IDLE at the same tick (mid-stop resync).
- **BREAK_WAIT:** stays until a synchronised high is seen → IDLE.
- **FIFO:**
  - Pop on `valid && ready`.
  - Push when full without a same-cycle pop → word dropped, `overrun` set.
  - Simultaneous push and pop when full → both happen, no overrun.
  - Simultaneous push and pop when empty → push lands; `valid` rises the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- **overrun:** a same-cycle set wins over `clear_overrun`.
- **rts_pin:** equals `count >= FIFO_DEPTH-1`. It is also 1 while `reset_n` is low.
- Mode inputs are sampled at each START entry and held for the frame. Mid-frame changes are ignored.

## Timing
- **Reset values:**
  - `valid`=0, `data_out`=0, `parity_error`=0, `frame_error`=0.
  - `overrun`=0, `break_detect`=0, `rts_pin`=1.
  - State IDLE; FIFO empty; divider 0.
  - `rts_pin` is 0 from the first cycle after release.
- **Reset mid-frame:** the partial word is discarded and the FIFO is emptied.
- **Latency:** `rx_pin` edge to synchroniser output is 2 cycles. Push to `valid` high is 1 cycle.
- **Head outputs** (`data_out`, flags) are registered FIFO head values and change only on a pop or on push-into-empty.
- **Pop** takes effect at the clock edge where `valid && ready`; the next head appears the same edge.
- **Frame length:** (1 + DATA_BITS + parity_en + stop bits) × OVERSAMPLE ticks. The push occurs at tick MID+1 of the last stop bit.

## Structure
- Package `usart_pkg`:
  - State enum.
  - Entry typedef {parity_error, frame_error, data}.
  - `MID` helper and `clog2` function.
- Sub-module `usart_fifo`: synchronous FIFO parameterised by WIDTH and DEPTH, exposing push, pop, full, empty and count. The receiver FSM, divider and voting live in the top level.

## Test plan
Defaults: `clocks_per_bit`=32 (div 2), OVERSAMPLE=16.
1. 8N1 frame 0xA5, `ready`=1 → one pop of 0xA5 with both error flags 0; `rts_pin`=0.
2. Even parity, 0x3C sent with parity bit 1 → `data_out`=0x3C, `parity_error`=1. Odd parity with bit 1 → no error.
3. Start glitch of 4 ticks low, then high → no push; state returns to IDLE. A following 0x55 is received correctly.
4. FIFO_DEPTH=4, `ready`=0, five frames 0x01..0x05:
   - `rts_pin`=1 after the third push.
   - `overrun`=1 after the fifth; 0x05 is dropped.
   - Drain order is 0x01..0x04.
   - `clear_overrun` → `overrun`=0.
5. Line held low for 2 frame times → exactly one `break_detect` pulse, no push. After the line returns high, 0x7E is received cleanly.
6. `two_stop`=1 with second stop bit low → `frame_error`=1. Separately, `reset_n` low mid-DATA → FIFO empty, `valid`=0, `rts_pin`=1, and the next frame is received correctly.
